// File: rtl/cd_rx_des_pkg.sv
// Shared definitions for the CDBUS receive deserializer: FSM encoding and CRC-16/MODBUS constants.
package cd_rx_des_pkg;

  typedef enum logic [4:0] {
    ST_WAIT  = 5'b00001,
    ST_START = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_STOP  = 5'b01000,
    ST_HOLD  = 5'b10000
  } rx_state_t;

  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Feeds one byte through the reflected CRC one bit at a time, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/cd_baud_rate.sv
// Bit-period timer: cap marks mid-bit, inc marks end of bit, both relative to the last restart.
module cd_baud_rate #(
  parameter bit FOR_TX = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] div_ls,
  input  logic [15:0] div_hs,
  input  logic        baud_sel,
  input  logic        sync,
  input  logic        sync_3x,
  output logic        cap,
  output logic        inc
);

  logic [15:0] div;
  logic [15:0] half;
  logic [15:0] cnt;
  logic        restart;

  assign div     = baud_sel ? div_hs : div_ls;
  assign half    = {1'b0, div[15:1]} + {15'd0, div[0]};
  // The 3x resync only matters for the transmit-side arbitration timing.
  assign restart = sync | (FOR_TX & sync_3x);

  // A divisor switch mid-period can leave cnt above the new div, hence >=.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        cnt <= '0;
    else if (restart)    cnt <= 16'd1;
    else if (cnt >= div) cnt <= '0;
    else                 cnt <= cnt + 16'd1;
  end

  assign cap = !restart && (cnt == half);
  assign inc = !restart && (cnt == 16'd0);

endmodule

// File: rtl/cd_crc.sv
// Running CRC-16/MODBUS register, preset by clean and advanced one byte per data_clk.
module cd_crc
  import cd_rx_des_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clean,
  input  logic        data_clk,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      crc_out <= CRC_INIT;
    else if (clean)    crc_out <= CRC_INIT;
    else if (data_clk) crc_out <= crc16_byte(crc_out, data);
  end

endmodule

// File: rtl/cd_rx_des.sv
// CDBUS receive deserializer: start detection, byte assembly, frame delimiting, break/error detection.
// state | meaning: WAIT hunt/idle, START verify start bit, DATA shift 8 bits, STOP check stop bit, HOLD wait line high
module cd_rx_des
  import cd_rx_des_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic [15:0] div_ls,
  input  logic [15:0] div_hs,
  input  logic [9:0]  frame_idle_len,
  output logic [7:0]  data,
  output logic        data_clk,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] crc_data,
  output logic        break_det,
  output logic        err,
  output logic        bus_idle
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_d;
  logic                   fall;
  logic                   sync;
  logic                   cap;
  logic                   inc;
  logic                   baud_sel;
  logic                   in_frame;
  logic                   idle_hit;
  rx_state_t              state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic [9:0]             idle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign fall     = rxs_d & ~rxs;
  assign sync     = ((state == ST_WAIT) && fall) || ((state == ST_HOLD) && rxs);
  // Widened compare so a zero idle length can never match.
  assign idle_hit = ({1'b0, idle_cnt} + 11'd1) == {1'b0, frame_idle_len};

  cd_baud_rate #(
    .FOR_TX (1'b0)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .div_ls   (div_ls),
    .div_hs   (div_hs),
    .baud_sel (baud_sel),
    .sync     (sync),
    .sync_3x  (1'b0),
    .cap      (cap),
    .inc      (inc)
  );

  cd_crc u_crc (
    .clk      (clk),
    .reset_n  (reset_n),
    .clean    (frame_end | break_det),
    .data_clk (data_clk),
    .data     (data),
    .crc_out  (crc_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_WAIT;
      rxs_d       <= 1'b1;
      bit_cnt     <= '0;
      shift       <= '0;
      idle_cnt    <= '0;
      in_frame    <= 1'b0;
      baud_sel    <= 1'b0;
      data        <= '0;
      data_clk    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      break_det   <= 1'b0;
      err         <= 1'b0;
      bus_idle    <= 1'b1;
    end else begin
      rxs_d       <= rxs;
      data_clk    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      break_det   <= 1'b0;
      err         <= 1'b0;
      if (state != ST_WAIT) idle_cnt <= '0;

      case (state)
        ST_WAIT: begin
          if (fall) begin
            state    <= ST_START;
            bus_idle <= 1'b0;
          end
          // Frame closing is independent of a start edge in the same cycle.
          if (inc && in_frame) begin
            if (idle_hit) begin
              frame_end <= 1'b1;
              in_frame  <= 1'b0;
              baud_sel  <= 1'b0;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 10'd1;
            end
          end
        end

        ST_START: begin
          if (cap) begin
            if (rxs) begin
              state    <= ST_WAIT;
              bus_idle <= 1'b1;
            end else begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (cap) begin
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (cap) begin
            if (rxs) begin
              data        <= shift;
              data_clk    <= 1'b1;
              frame_start <= !in_frame;
              in_frame    <= 1'b1;
              baud_sel    <= 1'b1;
              bus_idle    <= 1'b1;
              state       <= ST_WAIT;
            end else if (shift == 8'h00) begin
              break_det <= 1'b1;
              in_frame  <= 1'b0;
              baud_sel  <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              err   <= 1'b1;
              state <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (rxs) begin
            state    <= ST_WAIT;
            bus_idle <= 1'b1;
          end
        end

        default: begin
          state    <= ST_WAIT;
          bus_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule
